// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake and operand/result bundle for serial_adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, A, B, cin, input busy, done, sum, cout);
  modport slave  (input start, A, B, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one full-adder cell, WIDTH cycles per result
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             maj;
  logic [WIDTH-1:0] ps_next;

  assign s       = a_sr[0] ^ b_sr[0] ^ carry;
  assign maj     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign ps_next = {s, ps[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      ps     <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE so start held high streams results
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            carry  <= bus.cin;
            ps     <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= maj;
          ps    <= ps_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_r  <= ps_next;
            cout_r <= maj;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - vector table, corner sequences and scoreboard for serial_adder
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  int done4_cnt = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8_unexpected_done: got sum=0x%0h cout=%0b with no request pending", if8.sum, if8.cout);
      end else begin
        chk("sb8_result", {23'b0, if8.cout, if8.sum}, {23'b0, q8.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (if4.done === 1'b1) begin
      done4_cnt++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb4_unexpected_done: got sum=0x%0h cout=%0b with no request pending", if4.sum, if4.cout);
      end else begin
        chk("sb4_result", {27'b0, if4.cout, if4.sum}, {27'b0, q4.pop_front()});
      end
    end
  end

  // Called at a negedge; drives inputs, records an expected result if this edge accepts, advances one cycle.
  task automatic drive8(input logic st, input logic [7:0] a, input logic [7:0] b, input logic ci);
    if8.start = st;
    if8.A     = a;
    if8.B     = b;
    if8.cin   = ci;
    if (st && !if8.busy && !rst) q8.push_back({1'b0, a} + {1'b0, b} + {8'b0, ci});
    @(negedge clk);
  endtask

  task automatic idle8();
    drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output int lat, output logic busy_ok);
    drive8(1'b1, a, b, ci);
    lat = 0;
    busy_ok = 1'b1;
    while (!if8.done && lat < 20) begin
      if (!if8.busy) busy_ok = 1'b0;
      idle8();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic bok;
    int d0;
    int n;
    int last;
    int pulses;
    int issued;

    vecs[0] = '{8'h64, 8'h1B, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    rst = 1'b1;
    if8.start = 1'b0; if8.A = '0; if8.B = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, if8.busy}, 0);
    chk("reset_done", {31'b0, if8.done}, 0);
    chk("reset_sum", {24'b0, if8.sum}, 0);
    chk("reset_cout", {31'b0, if8.cout}, 0);
    chk("reset_busy4", {31'b0, if4.busy}, 0);
    rst = 1'b0;
    idle8();

    for (int i = 0; i < 8; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].ci, lat, bok);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_run", i), {31'b0, bok}, 1);
      chk($sformatf("vec%0d_busy_at_done", i), {31'b0, if8.busy}, 0);
      chk($sformatf("vec%0d_sum", i), {24'b0, if8.sum}, {24'b0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'b0, if8.cout}, {31'b0, vecs[i].co});
    end
    idle8();
    chk("done_single_cycle", {31'b0, if8.done}, 0);

    // start with other operands while a run is in progress must be ignored
    d0 = done8_cnt;
    drive8(1'b1, 8'h10, 8'h20, 1'b0);
    n = 0;
    while (!if8.done && n < 20) begin
      if (n >= 1 && n <= 6) drive8(1'b1, 8'h01, 8'h01, 1'b0);
      else idle8();
      n++;
    end
    chk("ignore_latency", n, 8);
    chk("ignore_result", {23'b0, if8.cout, if8.sum}, 9'h030);
    repeat (12) idle8();
    chk("ignore_one_pulse", done8_cnt - d0, 1);

    // reset in the middle of a run aborts it and clears the result
    drive8(1'b1, 8'h33, 8'h44, 1'b0);
    repeat (3) idle8();
    rst = 1'b1;
    idle8();
    chk("midrst_busy", {31'b0, if8.busy}, 0);
    chk("midrst_done", {31'b0, if8.done}, 0);
    chk("midrst_sum", {24'b0, if8.sum}, 0);
    chk("midrst_cout", {31'b0, if8.cout}, 0);
    q8.delete();
    rst = 1'b0;
    d0 = done8_cnt;
    repeat (14) idle8();
    chk("midrst_no_pulse", done8_cnt - d0, 0);
    run_op8(8'h64, 8'h1B, 1'b0, lat, bok);
    chk("after_rst_latency", lat, 8);
    chk("after_rst_result", {23'b0, if8.cout, if8.sum}, 9'h07F);
    idle8();

    // start held high: one result every WIDTH+1 cycles
    last = -1;
    pulses = 0;
    for (int cyc = 1; cyc <= 46; cyc++) begin
      drive8(1'b1, 8'h0F, 8'hF0, 1'b1);
      if (if8.done) begin
        pulses++;
        if (last >= 0) chk("held_interval", cyc - last, 9);
        chk("held_result", {23'b0, if8.cout, if8.sum}, 9'h100);
        last = cyc;
      end else if (last >= 0) begin
        chk("held_sum_stable", {23'b0, if8.cout, if8.sum}, 9'h100);
      end
    end
    chk("held_pulse_count", pulses, 5);
    n = 0;
    while (q8.size() != 0 && n < 30) begin
      idle8();
      n++;
    end
    chk("drain8_empty", q8.size(), 0);

    // WIDTH=4 exhaustive, issuing a new request whenever the adder is free
    issued = 0;
    n = 0;
    while ((issued < 512 || q4.size() != 0) && n < 4000) begin
      if (issued < 512 && !if4.busy) begin
        if4.start = 1'b1;
        {if4.cin, if4.A, if4.B} = 9'(issued);
        q4.push_back({1'b0, if4.A} + {1'b0, if4.B} + {4'b0, if4.cin});
        issued++;
      end else begin
        if4.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if4.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("w4_issued", issued, 512);
    chk("w4_done_count", done4_cnt, 512);
    chk("w4_queue_empty", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first. It uses a single full-adder cell and a registered carry. It consumes the same operand/carry triple as the combinational full adder and extends it to multi-bit words through a start/done handshake. It sits between operand registers and any consumer needing an area-cheap adder where WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.

- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result A+B+cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1, load shift registers a_sr<=A, b_sr<=B, carry<=cin, bit counter<=0, then go to RUN.
- RUN, each cycle:
  - s = a_sr[0]^b_sr[0]^carry;
  - carry <= majority(a_sr[0], b_sr[0], carry);
  - a_sr, b_sr shift right by one (zero fill);
  - s shifts into the MSB of the partial-sum register (right shift);
  - counter increments.
  - On the cycle that processes bit WIDTH-1, load the result registers sum<=final partial sum and cout<=final carry, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE: load and go to RUN.
  - Otherwise go to IDLE.
- start while busy=1 is ignored. A, B and cin are don't-care except on the accepting edge.
- sum and cout are held registers. They change only at completion and hold their value through IDLE and through a subsequent RUN until the next completion.
- Result is exact: {cout,sum} = A + B + cin, modulo 2^(WIDTH+1). No overflow is lost.
- Counter width is clog2(WIDTH); it must not wrap before the terminal compare (count == WIDTH-1).

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, and all internal registers 0. Reset takes priority over start.
- Reset mid-RUN aborts the operation. No done pulse follows, and sum/cout read 0.
- Accepting edge E0 (start=1, state IDLE or DONE): busy=1 from after E0.
- Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- After EWIDTH: busy=0, done=1, and sum/cout hold the new result.
- done deasserts after E(WIDTH+1).
- Latency from the start edge to done is WIDTH cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles, with start held high.
- No combinational path from any input to any output.

## Test plan
- WIDTH=8, after reset, A=0x64, B=0x1B, cin=0, start pulse -> done exactly 8 cycles after the start edge; sum=0x7F, cout=0; busy high for 8 cycles.
- WIDTH=8, A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1. Then A=0xA5, B=0x5A, cin=1 -> sum=0x00, cout=1. Then A=0, B=0, cin=0 -> sum=0x00, cout=0.
- Start re-asserted with different operands (A=0x01, B=0x01) during cycles 2..7 of a run of 0x10+0x20 -> ignored; result is sum=0x30, cout=0, with one done pulse only.
- start held high continuously with fixed A=0x0F, B=0xF0, cin=1 -> done pulses every 9 cycles, each with sum=0x00, cout=1; sum stays stable between pulses.
- rst asserted at cycle 4 of a run -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse ever follows. A fresh start then completes normally.
- WIDTH=4 exhaustive: all 512 combinations of A, B and cin -> {cout,sum} equals A+B+cin on every done pulse; done pulse count equals 512.
